// File: rtl/branch_recovery_unit_pkg.sv
// branch_recovery_unit_pkg
//   Shared types and constants for the dual-issue branch recovery unit:
//   default address width, recovery FSM state encoding, slot indices and
//   a helper that counts resolved branches in one EX cycle.
package branch_recovery_unit_pkg;

  localparam int unsigned BRU_ADDR_W = 10;

  // Slot indices into the per-slot EX pipe arrays.
  localparam int unsigned SLOT1     = 0;
  localparam int unsigned SLOT2     = 1;
  localparam int unsigned NUM_SLOTS = 2;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } bru_state_e;

  // Number of branches resolved this cycle (0..2).
  function automatic logic [1:0] branch_inc(input logic res1, input logic res2);
    return {1'b0, res1} + {1'b0, res2};
  endfunction

endpackage

// File: rtl/branch_recovery_unit_if.sv
// branch_recovery_unit_if
//   Pipeline <-> branch recovery unit bundle.
//   ID side : id_stall, Branch1_ID/Branch2_ID, BranchAddress_1_ID/_2_ID
//   EX side : Branch1_EX/Branch2_EX, taken1/taken2
//   Front-end correction: correct_en, correction, flush_IFID, flush_IDEX
//   MEM side: kill2_MEM (gate slot-2 MemWriteEn/RegWriteEn)
//   Modports: master = pipeline, slave = branch_recovery_unit.
interface branch_recovery_unit_if #(
  parameter int unsigned ADDR_W = branch_recovery_unit_pkg::BRU_ADDR_W
);
  logic              id_stall;
  logic              Branch1_ID;
  logic              Branch2_ID;
  logic [ADDR_W-1:0] BranchAddress_1_ID;
  logic [ADDR_W-1:0] BranchAddress_2_ID;
  logic              Branch1_EX;
  logic              Branch2_EX;
  logic              taken1;
  logic              taken2;
  logic              correct_en;
  logic [ADDR_W-1:0] correction;
  logic              flush_IFID;
  logic              flush_IDEX;
  logic              kill2_MEM;

  modport master (
    output id_stall, Branch1_ID, Branch2_ID, BranchAddress_1_ID, BranchAddress_2_ID,
    output Branch1_EX, Branch2_EX, taken1, taken2,
    input  correct_en, correction, flush_IFID, flush_IDEX, kill2_MEM
  );

  modport slave (
    input  id_stall, Branch1_ID, Branch2_ID, BranchAddress_1_ID, BranchAddress_2_ID,
    input  Branch1_EX, Branch2_EX, taken1, taken2,
    output correct_en, correction, flush_IFID, flush_IDEX, kill2_MEM
  );

endinterface

// File: rtl/branch_recovery_unit_shadow_ctr.sv
// bru_shadow_ctr
//   Post-redirect shadow counter. load presets the count to RECOVER_CYCLES;
//   a non-zero count decrements every cycle. done flags the last shadow
//   cycle (count == 1).
//   Ports: clk, rst (sync, active-low), load (in), done (out).
module bru_shadow_ctr #(
  parameter int unsigned RECOVER_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RECOVER_CYCLES[2:0];
    end else if (cnt != '0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign done = (cnt == 3'd1);

endmodule

// File: rtl/branch_recovery_unit.sv
// branch_recovery_unit
//   Resolves predicted-not-taken branches for the dual-issue pipeline.
//   Branch targets/valids are piped ID->EX; a taken branch in EX redirects
//   fetch in the same cycle and flushes IF/ID and ID/EX. A taken slot-1
//   branch suppresses the slot-2 outcome and kills the slot-2 instruction
//   one cycle later (its MEM cycle). After a redirect, EX outcomes are
//   ignored for RECOVER_CYCLES cycles.
//   Ports: clk, rst (sync, active-low), bus (branch_recovery_unit_if.slave),
//          branch_cnt, mispredict_cnt (performance counters).
//   Optional feature: define BRU_PERF_CNT_EN to implement the counters;
//   otherwise both counter ports are tied to 0.
module branch_recovery_unit
  import branch_recovery_unit_pkg::*;
#(
  parameter int unsigned ADDR_W         = BRU_ADDR_W,
  parameter int unsigned RECOVER_CYCLES = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_recovery_unit_if.slave bus,
  output logic [CNT_W-1:0]      branch_cnt,
  output logic [CNT_W-1:0]      mispredict_cnt
);

  logic [ADDR_W-1:0]    tgt_ex [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] v_ex;
  bru_state_e           state, state_next;
  logic                 shadow_load;
  logic                 shadow_done;
  logic                 r1, r2, correct;
  logic [ADDR_W-1:0]    correct_tgt;
  logic                 kill2;

  // ID -> EX target pipe; a flush or load-use bubble invalidates both slots.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tgt_ex[SLOT1] <= '0;
      tgt_ex[SLOT2] <= '0;
      v_ex          <= '0;
    end else if (correct || bus.id_stall) begin
      v_ex <= '0;
    end else begin
      tgt_ex[SLOT1] <= bus.BranchAddress_1_ID;
      tgt_ex[SLOT2] <= bus.BranchAddress_2_ID;
      v_ex[SLOT1]   <= bus.Branch1_ID;
      v_ex[SLOT2]   <= bus.Branch2_ID;
    end
  end

  // Resolution; the older slot-1 branch wins over slot-2.
  always_comb begin
    r1          = 1'b0;
    r2          = 1'b0;
    correct_tgt = '0;
    if (state == RUN) begin
      r1 = v_ex[SLOT1] & bus.Branch1_EX & bus.taken1;
      r2 = v_ex[SLOT2] & bus.Branch2_EX & bus.taken2 & ~r1;
    end
    correct = r1 | r2;
    if (r1) begin
      correct_tgt = tgt_ex[SLOT1];
    end else if (r2) begin
      correct_tgt = tgt_ex[SLOT2];
    end
  end

  assign bus.correct_en = correct;
  assign bus.correction = correct_tgt;
  assign bus.flush_IFID = correct;
  assign bus.flush_IDEX = correct;

  // Slot-2 of the same bundle reaches MEM one cycle after slot-1 resolves.
  always_ff @(posedge clk) begin
    if (!rst) begin
      kill2 <= 1'b0;
    end else begin
      kill2 <= r1;
    end
  end

  assign bus.kill2_MEM = kill2;

  // Recovery FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    shadow_load = 1'b0;
    case (state)
      RUN: begin
        if (correct) begin
          state_next  = SHADOW;
          shadow_load = 1'b1;
        end
      end
      SHADOW: begin
        if (shadow_done) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  bru_shadow_ctr #(
    .RECOVER_CYCLES(RECOVER_CYCLES)
  ) u_shadow_ctr (
    .clk  (clk),
    .rst  (rst),
    .load (shadow_load),
    .done (shadow_done)
  );

`ifdef BRU_PERF_CNT_EN
  logic       run_q;
  logic [1:0] br_inc;

  always_comb begin
    run_q  = (state == RUN);
    br_inc = branch_inc(run_q & v_ex[SLOT1] & bus.Branch1_EX,
                        run_q & v_ex[SLOT2] & bus.Branch2_EX & ~r1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      branch_cnt     <= branch_cnt + CNT_W'(br_inc);
      mispredict_cnt <= mispredict_cnt + CNT_W'(correct);
    end
  end
`else
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif

endmodule
